// File: rtl/regfile_debug_access.sv
// Debug-host initiator for the core register file: halts the core, does one read or write, and
// returns data/status. Optional write readback is enabled with `define REGFILE_DBG_READBACK_EN.
module regfile_debug_access #(
    parameter int unsigned REGISTER_DEPTH = 32,
    parameter int unsigned HALT_TIMEOUT   = 255
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [4:0]  i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_halt_req,
    input  logic        i_halt_ack,
    output logic [4:0]  o_rf_a1,
    input  logic [31:0] i_rf_rd1,
    output logic [4:0]  o_rf_a3,
    output logic        o_rf_we,
    output logic [31:0] o_rf_wd
);

    localparam int unsigned CntW = $clog2(HALT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StHaltWait,
        StAccess,
        StVerify,
        StResp
    } state_e;

    state_e         r_state;
    logic           r_write;
    logic [4:0]     r_addr;
    logic [31:0]    r_wdata;
    logic [CntW-1:0] r_cnt;
    logic           r_cmd_ready;
    logic           r_rsp_valid;
    logic [31:0]    r_rsp_rdata;
    logic           r_rsp_err;
    logic           r_halt_req;
    logic [4:0]     r_rf_a1;
    logic [4:0]     r_rf_a3;
    logic           r_rf_we;
    logic [31:0]    r_rf_wd;

    logic           w_addr_ok;
    logic [CntW-1:0] w_cnt_inc;

    assign w_addr_ok = 32'(i_cmd_addr) < REGISTER_DEPTH;
    // Saturating so the counter cannot wrap past the timeout value.
    assign w_cnt_inc = (r_cnt == CntW'(HALT_TIMEOUT)) ? r_cnt : r_cnt + CntW'(1);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state     <= StIdle;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_halt_req  <= 1'b0;
            r_rf_a1     <= '0;
            r_rf_a3     <= '0;
            r_rf_we     <= 1'b0;
            r_rf_wd     <= '0;
        end else begin
            // Register-file drive is a one-cycle pulse, re-armed only on entry to ACCESS/VERIFY.
            r_rf_a1 <= '0;
            r_rf_a3 <= '0;
            r_rf_we <= 1'b0;
            r_rf_wd <= '0;
            case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_write     <= i_cmd_write;
                        r_addr      <= i_cmd_addr;
                        r_wdata     <= i_cmd_wdata;
                        r_cmd_ready <= 1'b0;
                        if (!w_addr_ok) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= StResp;
                        end else begin
                            r_halt_req <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= StHaltWait;
                        end
                    end
                end
                StHaltWait: begin
                    if (i_halt_ack) begin
                        r_state <= StAccess;
                        if (r_write) begin
                            r_rf_we <= 1'b1;
                            r_rf_a3 <= r_addr;
                            r_rf_wd <= r_wdata;
                        end else begin
                            r_rf_a1 <= r_addr;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CntW'(HALT_TIMEOUT)) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= StResp;
                        end
                    end
                end
                StAccess: begin
`ifdef REGFILE_DBG_READBACK_EN
                    if (r_write) begin
                        r_rf_a1 <= r_addr;
                        r_state <= StVerify;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= (r_addr != 5'd0) ? i_rf_rd1 : 32'd0;
                        r_state     <= StResp;
                    end
`else
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= (!r_write && r_addr != 5'd0) ? i_rf_rd1 : 32'd0;
                    r_state     <= StResp;
`endif
                end
                StVerify: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= i_rf_rd1;
                    r_rsp_err   <= (r_addr != 5'd0) && (i_rf_rd1 != r_wdata);
                    r_state     <= StResp;
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_halt_req  <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_halt_req  = r_halt_req;
    assign o_rf_a1     = r_rf_a1;
    assign o_rf_a3     = r_rf_a3;
    assign o_rf_we     = r_rf_we;
    assign o_rf_wd     = r_rf_wd;

endmodule

// File: tb/tb_regfile_debug_access.sv
// Directed bench for regfile_debug_access: register-file model, response scoreboard and
// immediate-assertion checks; a second instance with 16 registers covers illegal addresses.
module tb_regfile_debug_access;

    localparam int unsigned TIMEOUT = 4;
`ifdef REGFILE_DBG_READBACK_EN
    localparam int WR_LAT = 4;
`else
    localparam int WR_LAT = 3;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        c16_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        halt_ack = 1'b0;

    logic        cmd_ready, rsp_valid, rsp_err, halt_req, rf_we;
    logic [31:0] rsp_rdata, rf_rd1, rf_wd;
    logic [4:0]  rf_a1, rf_a3;

    logic        c16_ready, c16_rsp_valid, c16_err, c16_halt, c16_we;
    logic [31:0] c16_rdata, c16_wd;
    logic [4:0]  c16_a1, c16_a3;
    logic [31:0] rd16 = 32'h5a5a_5a5a;

    logic [31:0] mem [32];
    int          we_cnt = 0;
    int          we_noack = 0;
    int          h16_cnt = 0;
    logic [4:0]  last_a3 = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    regfile_debug_access #(.REGISTER_DEPTH(32), .HALT_TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_resetn(resetn), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err), .o_halt_req(halt_req), .i_halt_ack(halt_ack), .o_rf_a1(rf_a1),
        .i_rf_rd1(rf_rd1), .o_rf_a3(rf_a3), .o_rf_we(rf_we), .o_rf_wd(rf_wd)
    );

    regfile_debug_access #(.REGISTER_DEPTH(16), .HALT_TIMEOUT(TIMEOUT)) dut16 (
        .i_clk(clk), .i_resetn(resetn), .i_cmd_valid(c16_valid), .o_cmd_ready(c16_ready),
        .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(c16_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(c16_rdata),
        .o_rsp_err(c16_err), .o_halt_req(c16_halt), .i_halt_ack(halt_ack), .o_rf_a1(c16_a1),
        .i_rf_rd1(rd16), .o_rf_a3(c16_a3), .o_rf_we(c16_we), .o_rf_wd(c16_wd)
    );

    // x0 deliberately not hardwired to zero so the block's own x0 forcing is exercised.
    assign rf_rd1 = mem[rf_a1];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (rf_we) begin
            mem[rf_a3] <= rf_wd;
        end
    end

    always @(posedge clk) begin
        if (rf_we) begin
            we_cnt  <= we_cnt + 1;
            last_a3 <= rf_a3;
        end
        if (rf_we && !halt_ack) we_noack <= we_noack + 1;
        if (c16_halt || c16_we) h16_cnt <= h16_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wr_rdata(input logic [31:0] wd);
`ifdef REGFILE_DBG_READBACK_EN
        return wd;
`else
        return 32'd0 & wd;
`endif
    endfunction

    // One full transaction on the main instance with response handshake.
    task automatic do_cmd(input string tag, input logic wr, input logic [4:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input int exp_we);
        int   lat;
        int   we0;
        logic hdrop;
        exp_t e;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        we0       = we_cnt;
        hdrop     = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        lat = 1;
        check({tag, "_halt_req_n1"}, 32'(halt_req), 32'd1);
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
            if (!halt_req) hdrop = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_halt_held"}, 32'(hdrop), 32'd0);
        check({tag, "_busy"}, 32'(cmd_ready), 32'd0);
        e = sb.pop_front();
        check({tag, "_rdata"}, rsp_rdata, e.rdata);
        check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        check({tag, "_we_pulses"}, 32'(we_cnt - we0), 32'(exp_we));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_post_halt"}, 32'(halt_req), 32'd0);
        check({tag, "_post_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   cnt;
        int   we0;
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_halt_req", 32'(halt_req), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_a1", 32'(rf_a1), 32'd0);
        @(posedge clk);
        #3 resetn = 1'b1;
        halt_ack = 1'b1;
        step();

        do_cmd("wr5", 1'b1, 5'd5, 32'hdead_beef, wr_rdata(32'hdead_beef), 1'b0, WR_LAT, 1);
        do_cmd("rd5", 1'b0, 5'd5, 32'h0, 32'hdead_beef, 1'b0, 3, 0);
        do_cmd("wr31", 1'b1, 5'd31, 32'h1234_5678, wr_rdata(32'h1234_5678), 1'b0, WR_LAT, 1);
        check("wr31_a3", 32'(last_a3), 32'd31);
        do_cmd("rd31", 1'b0, 5'd31, 32'h0, 32'h1234_5678, 1'b0, 3, 0);
        do_cmd("rd3", 1'b0, 5'd3, 32'h0, 32'h1000_0003, 1'b0, 3, 0);
        do_cmd("rd0_a", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 3, 0);
        do_cmd("wr0", 1'b1, 5'd0, 32'hffff_ffff, wr_rdata(32'hffff_ffff), 1'b0, WR_LAT, 1);
        check("wr0_a3", 32'(last_a3), 32'd0);
        do_cmd("rd0_b", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 3, 0);

        // Halt never acknowledged: error after TIMEOUT wait cycles, no write performed.
        halt_ack = 1'b0;
        do_cmd("tmo", 1'b1, 5'd7, 32'haaaa_5555, 32'h0, 1'b1, 1 + TIMEOUT, 0);
        halt_ack = 1'b1;
        do_cmd("rd7", 1'b0, 5'd7, 32'h0, 32'h1000_0007, 1'b0, 3, 0);

        // Illegal address on the 16-register instance.
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        c16_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 5'd20;
        check("ill_ready", 32'(c16_ready), 32'd1);
        step();
        c16_valid = 1'b0;
        e = sb.pop_front();
        check("ill_valid_n1", 32'(c16_rsp_valid), 32'd1);
        check("ill_err", 32'(c16_err), 32'(e.err));
        check("ill_rdata", c16_rdata, e.rdata);
        check("ill_halt", 32'(c16_halt), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("ill_post_valid", 32'(c16_rsp_valid), 32'd0);
        check("ill_no_halt_ever", 32'(h16_cnt), 32'd0);

        // Backpressure: response and halt held, second command ignored.
        sb.push_back('{rdata: 32'hdead_beef, err: 1'b0});
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 5'd5;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("bp_valid_n3", 32'(rsp_valid), 32'd1);
        we0 = we_cnt;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 5'd9;
        cmd_wdata = 32'h0bad_0bad;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'hdead_beef);
            check("bp_halt", 32'(halt_req), 32'd1);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        e = sb.pop_front();
        check("bp_rdata_sb", rsp_rdata, e.rdata);
        check("bp_err_sb", 32'(rsp_err), 32'(e.err));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_valid) cnt++;
        end
        check("bp_no_second_rsp", 32'(cnt), 32'd0);
        check("bp_no_write", 32'(we_cnt - we0), 32'd0);
        do_cmd("rd9", 1'b0, 5'd9, 32'h0, 32'h1000_0009, 1'b0, 3, 0);

        // Reset while waiting for halt_ack.
        halt_ack  = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 5'd4;
        cmd_wdata = 32'h4444_4444;
        step();
        cmd_valid = 1'b0;
        step();
        check("mid_halt_before", 32'(halt_req), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("mid_halt_req", 32'(halt_req), 32'd0);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rf_we", 32'(rf_we), 32'd0);
        check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        resetn   = 1'b1;
        halt_ack = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp_valid || halt_req) cnt++;
        end
        check("mid_no_stale", 32'(cnt), 32'd0);
        check("mid_ready_after", 32'(cmd_ready), 32'd1);
        check("we_without_ack", 32'(we_noack), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
